req_arbiter_6: RTL and testbench

//  Round-robin arbiter sharing one resource (bus/microcode service slot) among 6 requesters.

---
 rtl/arb6_pkg.sv | 22 ++
 rtl/rr_pick6.sv | 32 +++
 rtl/req_arbiter_6.sv | 135 +++++++++++++
 tb/tb_req_arbiter_6.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb6_pkg.sv
// Shared types and constants for the 6-way round-robin request arbiter.
package arb6_pkg;

    localparam int N_REQ = 6;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) id = id | ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin picker: first set request after last_id, wrapping 5 -> 0.
module rr_pick6
    import arb6_pkg::*;
(
    input  logic [N_REQ-1:0] req_q,
    input  logic [ID_W-1:0]  last_id,
    output logic [N_REQ-1:0] win_onehot,
    output logic [ID_W-1:0]  win_id,
    output logic             win_valid
);

    logic [ID_W-1:0] scan_idx;
    logic            found;

    always_comb begin
        win_onehot = '0;
        found      = 1'b0;
        scan_idx   = '0;
        // Scan last_id+1 .. last_id+6 so the previous owner is considered last.
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = ID_W'((int'(last_id) + k) % N_REQ);
            if (!found && req_q[scan_idx]) begin
                win_onehot[scan_idx] = 1'b1;
                found                = 1'b1;
            end
        end
    end

    assign win_id    = onehot_to_id(win_onehot);
    assign win_valid = |win_onehot;

endmodule

// File: rtl/req_arbiter_6.sv
// Round-robin arbiter granting one of 6 qualified requesters with a turnaround cycle.
// Optional hold watchdog enabled by defining REQ_ARB_TIMEOUT_EN.
module req_arbiter_6
    import arb6_pkg::*;
#(
    parameter logic [N_REQ-1:0] POLARITY_MASK = 6'b000000,
    parameter int               TIMEOUT       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_in,
    input  logic             enable,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic             any_req,
    output logic             timeout_err,
    output logic [1:0]       state_dbg
);

    // Handshake: grant_valid/grant_id describe the current owner; the owner holds the
    // resource until it asserts done (sampled only in GRANT) or drops its request.

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] req_q;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  owner_id;
    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  win_id;
    logic             win_valid;
    logic             load_grant;
    logic             drop_grant;
    logic             close_owner;
    logic             owner_gone;
    logic             timeout_hit;

    // The hold counter is 5 bits wide, so TIMEOUT values beyond 32 are not representable.
    if (TIMEOUT < 1 || TIMEOUT > 32) begin : g_timeout_out_of_range
    end

    rr_pick6 u_pick (
        .req_q      (req_q),
        .last_id    (last_id),
        .win_onehot (win_onehot),
        .win_id     (win_id),
        .win_valid  (win_valid)
    );

    assign owner_gone = ~req_q[grant_id];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_grant  = 1'b0;
        drop_grant  = 1'b0;
        close_owner = 1'b0;
        case (state)
            IDLE: begin
                if (enable && win_valid) begin
                    state_nxt  = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                if (done || owner_gone || timeout_hit) begin
                    state_nxt  = RELEASE;
                    drop_grant = 1'b1;
                end
            end
            RELEASE: begin
                state_nxt   = IDLE;
                close_owner = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_id resets to 5 so requester 0 is scanned first after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            owner_id    <= '0;
            last_id     <= ID_W'(N_REQ - 1);
        end else begin
            req_q <= req_in ^ POLARITY_MASK;
            if (load_grant) begin
                grant       <= win_onehot;
                grant_valid <= 1'b1;
                grant_id    <= win_id;
                owner_id    <= win_id;
            end else if (drop_grant) begin
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_id    <= '0;
            end
            if (close_owner) last_id <= owner_id;
        end
    end

`ifdef REQ_ARB_TIMEOUT_EN
    logic [4:0] hold_cnt;
    logic       timeout_flag;

    assign timeout_hit = (state == GRANT) && (hold_cnt == 5'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (load_grant)          hold_cnt <= '0;
            else if (state == GRANT) hold_cnt <= hold_cnt + 5'd1;
            // Only a release actually forced by the watchdog marks the error.
            if (timeout_hit && !done && !owner_gone) timeout_flag <= 1'b1;
        end
    end

    assign timeout_err = timeout_flag;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign any_req   = |req_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_req_arbiter_6.sv
// Bench for req_arbiter_6: directed vectors, grant ids checked by a queue-based monitor.
module tb_req_arbiter_6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] req_in, req_in_b;
    logic       enable, done, enable_b, done_b;
    logic [5:0] grant, grant_b;
    logic       grant_valid, grant_valid_b;
    logic [2:0] grant_id, grant_id_b;
    logic       any_req, any_req_b;
    logic       timeout_err, timeout_err_b;
    logic [1:0] state_dbg, state_dbg_b;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_id;
    logic [5:0] exp_oh;
    logic       gv_prev = 1'b0;
    int         held;

    always #5 clk = ~clk;

    req_arbiter_6 dut (
        .clock(clk), .reset(rst), .req_in(req_in), .enable(enable), .done(done),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
        .any_req(any_req), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    req_arbiter_6 #(.POLARITY_MASK(6'b100000)) dut_b (
        .clock(clk), .reset(rst), .req_in(req_in_b), .enable(enable_b), .done(done_b),
        .grant(grant_b), .grant_valid(grant_valid_b), .grant_id(grant_id_b),
        .any_req(any_req_b), .timeout_err(timeout_err_b), .state_dbg(state_dbg_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input int max_cycles, input string name);
        int n = 0;
        while (!grant_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!grant_valid) begin
            errors++;
            $display("FAIL %s: no grant within %0d cycles, expected a grant", name, max_cycles);
        end
    endtask

    // Monitor: every new grant on the main DUT is matched against the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            gv_prev = 1'b0;
        end else begin
            if (grant_valid && !gv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: grant_id %0d expected no grant", grant_id);
                end else begin
                    exp_id = exp_q.pop_front();
                    exp_oh = 6'b000001 << exp_id;
                    check("mon_grant_id", grant_id, exp_id);
                    check("mon_grant", grant, exp_oh);
                end
            end
            gv_prev = grant_valid;
        end
    end

    initial begin
        req_in   = 6'b000000;
        enable   = 1'b0;
        done     = 1'b0;
        req_in_b = 6'b100000;
        enable_b = 1'b1;
        done_b   = 1'b0;
        step(2);

        // reset state
        check("rst_grant", grant, 6'b000000);
        check("rst_gv", grant_valid, 1'b0);
        check("rst_gid", grant_id, 3'd0);
        check("rst_any", any_req, 1'b0);
        check("rst_tmo", timeout_err, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        check("rst_grant_b", grant_b, 6'b000000);

        // single requester 0: grant on second edge after reset release
        rst    = 1'b0;
        req_in = 6'b000001;
        enable = 1'b1;
        exp_q.push_back(3'd0);
        step(1);
        check("t1_any_req", any_req, 1'b1);
        check("t1_not_yet", grant_valid, 1'b0);
        step(1);
        check("t1_grant", grant, 6'b000001);
        check("t1_gid", grant_id, 3'd0);
        done = 1'b1;
        step(1);
        check("t1_release", grant, 6'b000000);
        done   = 1'b0;
        req_in = 6'b000000;
        step(3);

        // active-low input 5 on the masked instance
        check("t3_idle_any", any_req_b, 1'b0);
        check("t3_idle_gv", grant_valid_b, 1'b0);
        req_in_b = 6'b000000;
        step(2);
        check("t3_grant", grant_b, 6'b100000);
        check("t3_gid", grant_id_b, 3'd5);
        check("t3_any", any_req_b, 1'b1);
        req_in_b = 6'b100000;
        step(2);
        check("t3_drop", grant_valid_b, 1'b0);

        // full rotation from reset: 0,1,2,3,4,5,0 with two dead cycles between owners
        rst = 1'b1;
        step(1);
        rst    = 1'b0;
        req_in = 6'b111111;
        for (int i = 0; i < 7; i++) exp_q.push_back(3'(i % 6));
        wait_grant(10, "t2_first");
        for (int i = 0; i < 7; i++) begin
            done = 1'b1;
            if (i == 6) req_in = 6'b000000;
            step(1);
            check("t2_gap1", grant_valid, 1'b0);
            done = 1'b0;
            step(1);
            check("t2_gap2", grant_valid, 1'b0);
            if (i < 6) begin
                step(1);
                check("t2_next", grant_valid, 1'b1);
            end
        end
        step(2);

        // enable drops while owner 2 holds the grant
        req_in = 6'b000100;
        exp_q.push_back(3'd2);
        wait_grant(10, "t4_grant");
        check("t4_gid", grant_id, 3'd2);
        enable = 1'b0;
        req_in = 6'b111111;
        step(5);
        check("t4_held", grant, 6'b000100);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("t4_release", grant_valid, 1'b0);
        step(6);
        check("t4_no_new", grant_valid, 1'b0);
        check("t4_any", any_req, 1'b1);
        exp_q.push_back(3'd3);
        enable = 1'b1;
        wait_grant(10, "t4_resume");
        check("t4_gid3", grant_id, 3'd3);

        // asynchronous reset while owner 3 holds the grant
        #2 rst = 1'b1;
        #1;
        check("t5_async_grant", grant, 6'b000000);
        check("t5_async_gv", grant_valid, 1'b0);
        check("t5_async_gid", grant_id, 3'd0);
        @(negedge clk);
        req_in = 6'b001001;
        rst    = 1'b0;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd3);
        wait_grant(10, "t5_first");
        check("t5_gid0", grant_id, 3'd0);
        done = 1'b1;
        step(1);
        done = 1'b0;
        wait_grant(10, "t5_second");
        check("t5_gid3", grant_id, 3'd3);
        req_in = 6'b000000;
        step(4);
        check("t5_drop", grant_valid, 1'b0);

        // watchdog: done never asserted
        req_in = 6'b000010;
        exp_q.push_back(3'd1);
`ifdef REQ_ARB_TIMEOUT_EN
        exp_q.push_back(3'd1);
`endif
        wait_grant(10, "t6_grant");
        held = 0;
        while (grant_valid && held < 120) begin
            held++;
            step(1);
        end
`ifdef REQ_ARB_TIMEOUT_EN
        check("t6_hold_cycles", held, 16);
        check("t6_tmo_set", timeout_err, 1'b1);
        wait_grant(10, "t6_regrant");
        check("t6_tmo_sticky", timeout_err, 1'b1);
        req_in = 6'b000000;
        step(4);
        check("t6_tmo_after", timeout_err, 1'b1);
`else
        check("t6_hold_cycles", held, 120);
        check("t6_tmo_zero", timeout_err, 1'b0);
        req_in = 6'b000000;
        step(3);
        check("t6_drop", grant_valid, 1'b0);
`endif

        step(2);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
